// File: rtl/bitwave_pkg.sv
// Constants and beat tag type shared by the bit-serial dot-product column path.
// Products are signed lane results; bit indices address weight magnitude bits.
package bitwave_pkg;

  localparam int PROD_W   = 8;
  localparam int MAG_BITS = 7;
  localparam int IDX_W    = 3;

  // Per-beat control that travels alongside the shifted lane sum.
  typedef struct packed {
    logic first;
    logic last;
    logic bad_idx;
  } beat_tag_t;

endpackage

// File: rtl/bs_adder_tree.sv
// Combinational sign-extending sum of LANES packed signed products.
// Nodes are laid out heap-style: leaves at LANES..2*LANES-1, root at index 1.
module bs_adder_tree #(
  parameter int LANES  = 8,
  parameter int PROD_W = 8,
  parameter int OUT_W  = 24
) (
  input  logic [LANES*PROD_W-1:0] prod,
  output logic signed [OUT_W-1:0] sum
);

  logic signed [OUT_W-1:0] node [1:2*LANES-1];

  genvar i;
  generate
    for (i = 0; i < LANES; i = i + 1) begin : g_leaf
      assign node[LANES+i] = {{(OUT_W-PROD_W){prod[i*PROD_W+PROD_W-1]}},
                              prod[i*PROD_W +: PROD_W]};
    end
    for (i = 1; i < LANES; i = i + 1) begin : g_node
      assign node[i] = node[2*i] + node[2*i+1];
    end
  endgenerate

  assign sum = node[1];

endmodule

// File: rtl/bs_col_accumulator.sv
// Two-stage column accumulator: stage 1 sums and shifts one weight bit-column,
// stage 2 folds it into the open group and publishes a result on the last beat.
module bs_col_accumulator #(
  parameter int LANES  = 8,
  parameter int PROD_W = bitwave_pkg::PROD_W,
  parameter int ACC_W  = 24,
  parameter int CNT_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*PROD_W-1:0] in_prod,
  input  logic [2:0]              in_bit_idx,
  input  logic                    in_first,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ACC_W-1:0]        out_acc,
  output logic [CNT_W-1:0]        out_beats,
  output logic                    protocol_err
);
  import bitwave_pkg::*;

  logic                    pipe_en;
  logic signed [ACC_W-1:0] lane_sum;
  logic signed [ACC_W-1:0] shifted;
  logic                    idx_bad;

  logic                    s1_valid;
  logic signed [ACC_W-1:0] s1_data;
  beat_tag_t               s1_tag;

  logic                    grp_open;
  logic signed [ACC_W-1:0] acc;
  logic [CNT_W-1:0]        cnt;

  logic                    s2_fire;
  logic                    start;
  logic signed [ACC_W-1:0] base_acc;
  logic [CNT_W-1:0]        base_cnt;
  logic signed [ACC_W-1:0] nxt_acc;
  logic [CNT_W-1:0]        nxt_cnt;
  logic                    beat_err;

  assign pipe_en  = !out_valid || out_ready;
  assign in_ready = pipe_en;

  bs_adder_tree #(
    .LANES  (LANES),
    .PROD_W (PROD_W),
    .OUT_W  (ACC_W)
  ) u_tree (
    .prod (in_prod),
    .sum  (lane_sum)
  );

  // Index 7 is not a magnitude bit; such a beat is carried through as zero.
  assign idx_bad = (in_bit_idx >= IDX_W'(MAG_BITS));
  assign shifted = idx_bad ? '0 : (lane_sum <<< in_bit_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_tag   <= '0;
    end else if (pipe_en) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data        <= shifted;
        s1_tag.first   <= in_first;
        s1_tag.last    <= in_last;
        s1_tag.bad_idx <= idx_bad;
      end
    end
  end

  // A beat restarts the group when flagged first or when nothing is open.
  always_comb begin
    s2_fire  = pipe_en && s1_valid;
    start    = s1_tag.first || !grp_open;
    base_acc = start ? '0 : acc;
    base_cnt = start ? '0 : cnt;
    nxt_acc  = base_acc;
    nxt_cnt  = base_cnt;
    if (!s1_tag.bad_idx) begin
      nxt_acc = base_acc + s1_data;
      nxt_cnt = (base_cnt == '1) ? base_cnt : base_cnt + CNT_W'(1);
    end
    beat_err = (s1_tag.first && grp_open) || (!s1_tag.first && !grp_open) ||
               s1_tag.bad_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grp_open     <= 1'b0;
      acc          <= '0;
      cnt          <= '0;
      out_acc      <= '0;
      out_beats    <= '0;
      protocol_err <= 1'b0;
    end else if (s2_fire) begin
      if (s1_tag.last) begin
        out_acc   <= nxt_acc;
        out_beats <= nxt_cnt;
        acc       <= '0;
        cnt       <= '0;
        grp_open  <= 1'b0;
      end else begin
        acc      <= nxt_acc;
        cnt      <= nxt_cnt;
        grp_open <= 1'b1;
      end
      if (beat_err) begin
        protocol_err <= 1'b1;
      end
    end
  end

  // A completing last re-asserts valid in the same cycle the old result drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
    end else if (s2_fire && s1_tag.last) begin
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
